// File: rtl/boot_loader_if.sv
// Byte-stream input, memory write port and status outputs of the boot loader,
// bundled so the loader and its environment share one declaration.
interface boot_loader_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  cpu_hold;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
    );
endinterface

// File: rtl/boot_loader.sv
// Receives a framed program image byte by byte and writes it word by word into
// the instruction/data memory, holding the CPU in reset while loading.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for MAGIC, non-MAGIC bytes discarded
// S_LEN_LO | waiting for low byte of the word count
// S_LEN_HI | waiting for high byte of the word count, range-checked
// S_DATA   | collecting the four bytes of the current word
// S_WRITE  | one-cycle memory write strobe, input stalled
// S_CSUM   | waiting for the checksum byte
module boot_loader #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          MEM_SIZE   = 1 << ADDR_WIDTH,
    parameter logic [7:0]  MAGIC      = 8'hA5
) (
    input  logic          clk,
    input  logic          rst_n,
    boot_loader_if.slave  bus
);
    localparam int IW = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            sum_q, sum_d;
    logic [IW-1:0]         widx_q, widx_d;
    logic [1:0]            bidx_q, bidx_d;
    logic [23:0]           word_q, word_d;
    logic                  in_ready_q, in_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  hold_q, hold_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  accept;
    logic [7:0]            sum_add;
    logic [15:0]           len_full;
    logic                  len_over;
    logic                  last_word;

    assign accept    = bus.in_valid && in_ready_q;
    assign sum_add   = sum_q + bus.in_data;
    assign len_full  = {bus.in_data, len_q[7:0]};
    assign len_over  = {1'b0, len_full} > 17'(MEM_SIZE);
    // Word index is one bit wider than the address so N = MEM_SIZE terminates cleanly.
    assign last_word = (17'(widx_q) + 17'd1) == {1'b0, len_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            sum_q       <= '0;
            widx_q      <= '0;
            bidx_q      <= '0;
            word_q      <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hold_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            widx_q      <= widx_d;
            bidx_q      <= bidx_d;
            word_q      <= word_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hold_q      <= hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        widx_d      = widx_q;
        bidx_d      = bidx_q;
        word_d      = word_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hold_d      = hold_q;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            S_IDLE: begin
                if (accept && bus.in_data == MAGIC) begin
                    state_d = S_LEN_LO;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    sum_d   = '0;
                    widx_d  = '0;
                    bidx_d  = '0;
                    hold_d  = 1'b1;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d   = {8'h00, bus.in_data};
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else if (len_over) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    sum_d  = sum_add;
                    word_d = {bus.in_data, word_q[23:8]};
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        state_d     = S_WRITE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = widx_q[ADDR_WIDTH-1:0];
                        mem_wdata_d = {bus.in_data, word_q};
                    end
                end
            end
            S_WRITE: begin
                widx_d  = widx_q + IW'(1);
                state_d = last_word ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = S_IDLE;
                    if (sum_add == 8'h00) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d != S_WRITE);
        busy_d     = (state_d != S_IDLE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_hold  = hold_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a table of frames with hand-computed writes
// and status, plus sequences for a full-memory image and reset mid-frame.
module tb_boot_loader;
    localparam int AW   = 12;
    localparam int MSZ  = 1 << AW;
    localparam int LOGN = 8192;

    typedef logic [0:15][7:0] frame_t;

    typedef struct {
        string       name;
        int          nb;
        frame_t      b;
        bit          gaps;
        int          exp_wr;
        logic [31:0] a0, d0, a1, d1;
        logic        done, err, hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    boot_loader_if #(.ADDR_WIDTH(AW)) bif ();

    boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: logs every strobe seen, and whether in_ready was low and
    // the strobe was isolated from the previous cycle's strobe.
    int          wr_total = 0;
    logic [AW-1:0] log_addr [LOGN];
    logic [31:0] log_data [LOGN];
    bit          log_viol [LOGN];
    bit          prev_we = 1'b0;

    always @(negedge clk) begin
        if (bif.mem_we === 1'b1) begin
            log_addr[wr_total % LOGN] <= bif.mem_addr;
            log_data[wr_total % LOGN] <= bif.mem_wdata;
            log_viol[wr_total % LOGN] <= (bif.in_ready !== 1'b0) || prev_we;
            wr_total <= wr_total + 1;
        end
        prev_we <= (bif.mem_we === 1'b1);
    end

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vt [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic frame_t al(input int n, input logic [127:0] x);
        return frame_t'(x << (8 * (16 - n)));
    endfunction

    task automatic set_vec(input int idx, input string name, input int nb, input logic [127:0] bytes,
                           input bit gaps, input int exp_wr,
                           input logic [31:0] a0, input logic [31:0] d0,
                           input logic [31:0] a1, input logic [31:0] d1,
                           input logic done, input logic err, input logic hold);
        vt[idx].name = name;   vt[idx].nb = nb;   vt[idx].b = al(nb, bytes);
        vt[idx].gaps = gaps;   vt[idx].exp_wr = exp_wr;
        vt[idx].a0 = a0; vt[idx].d0 = d0; vt[idx].a1 = a1; vt[idx].d1 = d1;
        vt[idx].done = done; vt[idx].err = err; vt[idx].hold = hold;
    endtask

    // Returns 1 time unit after the edge on which the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int budget;
        if (gap) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                bif.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_data  = b;
        budget = 0;
        while (bif.in_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (bif.in_ready !== 1'b1) check("accept_timeout", 32'(bif.in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic end_frame();
        @(negedge clk);
        bif.in_valid = 1'b0;
    endtask

    task automatic check_status(input string name, input logic done, input logic err, input logic hold);
        check({name, "_done"}, 32'(bif.done), 32'(done));
        check({name, "_error"}, 32'(bif.error), 32'(err));
        check({name, "_hold"}, 32'(bif.cpu_hold), 32'(hold));
        check({name, "_busy"}, 32'(bif.busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        int          viol;
        int          bad;
        int          t0;
        int          t1;
        logic [7:0]  s;
        logic [31:0] wv;

        bif.in_valid = 1'b0;
        bif.in_data  = 8'h00;

        // Payload sums: 0x78+0x56+0x34+0x12+0xEF+0xBE+0xAD+0xDE = 0x44C -> csum 0xB4.
        set_vec(0, "good", 12, {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB4}, 1'b0, 2,
                32'd0, 32'h12345678, 32'd1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        set_vec(1, "badcsum", 12, {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00}, 1'b0, 2,
                32'd0, 32'h12345678, 32'd1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1);
        set_vec(2, "oversize", 3, {8'hA5, 8'h01, 8'h10}, 1'b0, 0,
                32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        set_vec(3, "good2", 12, {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB4}, 1'b0, 2,
                32'd0, 32'h12345678, 32'd1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        set_vec(4, "noisegap", 15, {8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h02, 8'h00, 8'h78,
                8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB4}, 1'b1, 2,
                32'd0, 32'h12345678, 32'd1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        set_vec(5, "empty", 4, {8'hA5, 8'h00, 8'h00, 8'h00}, 1'b0, 0,
                32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        set_vec(6, "emptybad", 4, {8'hA5, 8'h00, 8'h00, 8'h01}, 1'b0, 0,
                32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        set_vec(7, "oneword", 8, {8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6},
                1'b1, 1, 32'd0, 32'h04030201, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bif.in_ready), 32'd0);
        check("rst_mem_we", 32'(bif.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bif.mem_addr), 32'd0);
        check("rst_mem_wdata", bif.mem_wdata, 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bif.in_ready), 32'd1);

        for (int k = 0; k < 8; k++) begin
            base = wr_total;
            for (int i = 0; i < vt[k].nb; i++) send_byte(vt[k].b[i], vt[k].gaps);
            end_frame();
            check({vt[k].name, "_nwr"}, 32'(wr_total - base), 32'(vt[k].exp_wr));
            if (vt[k].exp_wr > 0) begin
                viol = 0;
                for (int i = 0; i < vt[k].exp_wr; i++) viol += int'(log_viol[(base + i) % LOGN]);
                check({vt[k].name, "_we_pulse"}, 32'(viol), 32'd0);
                check({vt[k].name, "_a0"}, 32'(log_addr[base % LOGN]), vt[k].a0);
                check({vt[k].name, "_d0"}, log_data[base % LOGN], vt[k].d0);
            end
            if (vt[k].exp_wr > 1) begin
                check({vt[k].name, "_a1"}, 32'(log_addr[(base + 1) % LOGN]), vt[k].a1);
                check({vt[k].name, "_d1"}, log_data[(base + 1) % LOGN], vt[k].d1);
            end
            check_status(vt[k].name, vt[k].done, vt[k].err, vt[k].hold);
        end

        // Full-memory image: N = MEM_SIZE, word i = i.
        base = wr_total;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        s  = 8'h00;
        t0 = 0;
        t1 = 0;
        for (int w = 0; w < MSZ; w++) begin
            wv = 32'(w);
            s  = s + wv[7:0] + wv[15:8];
            send_byte(wv[7:0], 1'b0);
            if (w == 0) t0 = cyc;
            send_byte(wv[15:8], 1'b0);
            send_byte(8'h00, 1'b0);
            send_byte(8'h00, 1'b0);
        end
        t1 = cyc;
        send_byte(8'h00 - s, 1'b0);
        end_frame();
        bad = 0;
        for (int i = 0; i < MSZ; i++) begin
            if (log_addr[(base + i) % LOGN] !== AW'(i) || log_data[(base + i) % LOGN] !== 32'(i)
                || log_viol[(base + i) % LOGN]) bad++;
        end
        check("full_nwr", 32'(wr_total - base), 32'(MSZ));
        check("full_words", 32'(bad), 32'd0);
        check("full_last_addr", 32'(log_addr[(base + MSZ - 1) % LOGN]), 32'(MSZ - 1));
        check("full_rate", 32'(t1 - t0), 32'd20478);
        check_status("full", 1'b1, 1'b0, 1'b0);

        // Reset after the 5th payload byte of a frame.
        base = wr_total;
        send_byte(8'hA5, 1'b0);
        check("mid_busy", 32'(bif.busy), 32'd1);
        check("mid_hold", 32'(bif.cpu_hold), 32'd1);
        check("mid_done_cleared", 32'(bif.done), 32'd0);
        for (int i = 1; i < 8; i++) send_byte(vt[0].b[i], 1'b0);
        check("mid_nwr", 32'(wr_total - base), 32'd1);
        #1;
        rst_n = 1'b0;
        bif.in_valid = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(bif.in_ready), 32'd0);
        check("mid_rst_mem_we", 32'(bif.mem_we), 32'd0);
        check("mid_rst_mem_addr", 32'(bif.mem_addr), 32'd0);
        check("mid_rst_mem_wdata", bif.mem_wdata, 32'd0);
        check_status("mid_rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        base = wr_total;
        for (int i = 0; i < vt[0].nb; i++) send_byte(vt[0].b[i], 1'b0);
        end_frame();
        check("after_rst_nwr", 32'(wr_total - base), 32'd2);
        check("after_rst_a0", 32'(log_addr[base % LOGN]), 32'd0);
        check("after_rst_d0", log_data[base % LOGN], 32'h12345678);
        check("after_rst_a1", 32'(log_addr[(base + 1) % LOGN]), 32'd1);
        check_status("after_rst", 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
